// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for the hazard scoreboard: stage register fields and
// qualifiers in, stall/flush/forward controls and scoreboard status out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_BITS = 5,
  parameter int FWD_STAGES    = 2,
  parameter int MAX_OUT       = 4,
  parameter int CNT_BITS      = 32
);
  localparam int FWD_W = $clog2(FWD_STAGES + 1);
  localparam int PC_W  = $clog2(MAX_OUT + 1);

  logic [REG_ADDR_BITS-1:0]            rs1D, rs2D, rdD;
  logic                                rs1UsedD, rs2UsedD, regWriteD;
  logic [REG_ADDR_BITS-1:0]            rs1E, rs2E, rdE;
  logic                                validE, regWriteE, loadE, longOpE, mispredictE;
  logic [FWD_STAGES*REG_ADDR_BITS-1:0] fwdRd;
  logic [FWD_STAGES-1:0]               fwdWe;
  logic                                cplValid;
  logic [REG_ADDR_BITS-1:0]            cplRd;
  logic                                stallF, stallD, stallE, flushD, flushE;
  logic [FWD_W-1:0]                    forwardAE, forwardBE;
  logic [PC_W-1:0]                     pendingCount;
  logic [CNT_BITS-1:0]                 stallCycles;

  modport master (
    output rs1D, rs2D, rdD, rs1UsedD, rs2UsedD, regWriteD,
    output rs1E, rs2E, rdE, validE, regWriteE, loadE, longOpE, mispredictE,
    output fwdRd, fwdWe, cplValid, cplRd,
    input  stallF, stallD, stallE, flushD, flushE,
    input  forwardAE, forwardBE, pendingCount, stallCycles
  );

  modport slave (
    input  rs1D, rs2D, rdD, rs1UsedD, rs2UsedD, regWriteD,
    input  rs1E, rs2E, rdE, validE, regWriteE, loadE, longOpE, mispredictE,
    input  fwdRd, fwdWe, cplValid, cplRd,
    output stallF, stallD, stallE, flushD, flushE,
    output forwardAE, forwardBE, pendingCount, stallCycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a register scoreboard for out-of-order variable-latency ops:
// load-use/long-use/RAW/WAW/structural stalls, flushes and priority forwarding.
module hazard_scoreboard #(
  parameter int REG_ADDR_BITS = 5,
  parameter int NUM_REGS      = 32,
  parameter int FWD_STAGES    = 2,
  parameter int MAX_OUT       = 4,
  parameter int CNT_BITS      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int FWD_W = $clog2(FWD_STAGES + 1);
  localparam int PC_W  = $clog2(MAX_OUT + 1);

  logic [NUM_REGS-1:0] pending;
  logic [PC_W-1:0]     pending_count;
  logic [CNT_BITS-1:0] stall_cycles;

  logic full, dispatch, cpl_clear;
  logic rs1_busy, rs2_busy, rd_busy, rd_e_match;
  logic load_use, long_use, raw_busy, waw_busy, struct_stall, stall;
  logic [FWD_W-1:0] fwd_a, fwd_b;

  assign full      = (pending_count == PC_W'(MAX_OUT));
  assign dispatch  = bus.validE & bus.longOpE & bus.regWriteE & (bus.rdE != '0) & ~full;
  assign cpl_clear = bus.cplValid & pending[bus.cplRd];

  // A completing register is already free this cycle; its data is bypassed outside.
  assign rs1_busy = pending[bus.rs1D] & ~(bus.cplValid & (bus.cplRd == bus.rs1D));
  assign rs2_busy = pending[bus.rs2D] & ~(bus.cplValid & (bus.cplRd == bus.rs2D));
  assign rd_busy  = pending[bus.rdD]  & ~(bus.cplValid & (bus.cplRd == bus.rdD));

  assign rd_e_match = (bus.rdE != '0) &
                      ((bus.rs1UsedD & (bus.rs1D == bus.rdE)) |
                       (bus.rs2UsedD & (bus.rs2D == bus.rdE)));

  assign load_use     = bus.validE & bus.loadE & rd_e_match;
  assign long_use     = bus.validE & bus.longOpE & rd_e_match;
  assign raw_busy     = (rs1_busy & bus.rs1UsedD) | (rs2_busy & bus.rs2UsedD);
  assign waw_busy     = bus.regWriteD & rd_busy;
  assign struct_stall = bus.validE & bus.longOpE & bus.regWriteE & full;
  assign stall        = struct_stall | load_use | long_use | raw_busy | waw_busy;

  assign bus.stallE = struct_stall;
  assign bus.stallD = stall;
  assign bus.stallF = stall;
  assign bus.flushD = bus.mispredictE;
  assign bus.flushE = bus.mispredictE | (stall & ~struct_stall);

  // Scan oldest to youngest so the youngest matching stage overwrites the choice.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (bus.fwdWe[i] && (bus.rs1E != '0) &&
          (bus.fwdRd[i*REG_ADDR_BITS +: REG_ADDR_BITS] == bus.rs1E))
        fwd_a = FWD_W'(i + 1);
      if (bus.fwdWe[i] && (bus.rs2E != '0) &&
          (bus.fwdRd[i*REG_ADDR_BITS +: REG_ADDR_BITS] == bus.rs2E))
        fwd_b = FWD_W'(i + 1);
    end
  end

  assign bus.forwardAE    = fwd_a;
  assign bus.forwardBE    = fwd_b;
  assign bus.pendingCount = pending_count;
  assign bus.stallCycles  = stall_cycles;

  // The set is issued after the clear so a same-register dispatch keeps the bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_count <= '0;
      stall_cycles  <= '0;
    end else begin
      if (cpl_clear)
        pending[bus.cplRd] <= 1'b0;
      if (dispatch)
        pending[bus.rdE] <= 1'b1;
      if (dispatch && !cpl_clear)
        pending_count <= pending_count + PC_W'(1);
      else if (cpl_clear && !dispatch)
        pending_count <= pending_count - PC_W'(1);
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a set-of-pending-registers reference model.
module tb_hazard_scoreboard;
  localparam int RAB = 5;
  localparam int FS  = 2;
  localparam int MO  = 4;
  localparam int CB  = 4;
  localparam int STALL_MAX = (1 << CB) - 1;

  typedef struct {
    logic [4:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, cplRd;
    logic       rs1UsedD, rs2UsedD, regWriteD;
    logic       validE, regWriteE, loadE, longOpE, mispredictE, cplValid;
    logic [9:0] fwdRd;
    logic [1:0] fwdWe;
  } stim_t;

  logic clk;
  logic rst_n;
  int   assert_count = 0;
  int   fail_count   = 0;

  bit m_pend [32];
  int m_stall;

  hazard_scoreboard_if #(.REG_ADDR_BITS(RAB), .FWD_STAGES(FS), .MAX_OUT(MO), .CNT_BITS(CB)) bus ();

  hazard_scoreboard #(
    .REG_ADDR_BITS(RAB), .NUM_REGS(32), .FWD_STAGES(FS), .MAX_OUT(MO), .CNT_BITS(CB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rs1D = 0; s.rs2D = 0; s.rdD = 0; s.rs1E = 0; s.rs2E = 0; s.rdE = 0; s.cplRd = 0;
    s.rs1UsedD = 0; s.rs2UsedD = 0; s.regWriteD = 0;
    s.validE = 0; s.regWriteE = 0; s.loadE = 0; s.longOpE = 0; s.mispredictE = 0; s.cplValid = 0;
    s.fwdRd = 0; s.fwdWe = 0;
    return s;
  endfunction

  function automatic stim_t longOp(input logic [4:0] rd);
    stim_t s = idle();
    s.validE = 1; s.longOpE = 1; s.regWriteE = 1; s.rdE = rd;
    return s;
  endfunction

  function automatic stim_t loadUse(input logic [4:0] rd);
    stim_t s = idle();
    s.validE = 1; s.loadE = 1; s.regWriteE = 1; s.rdE = rd;
    s.rs1D = rd; s.rs1UsedD = 1;
    return s;
  endfunction

  function automatic int occupancy();
    int n = 0;
    foreach (m_pend[r]) n += int'(m_pend[r]);
    return n;
  endfunction

  function automatic bit busy(input int r, input stim_t s);
    return m_pend[r] && !(s.cplValid && int'(s.cplRd) == r);
  endfunction

  function automatic int fwdPick(input logic [4:0] rs, input stim_t s);
    for (int i = 0; i < FS; i++)
      if (rs != 0 && s.fwdWe[i] && s.fwdRd[i*5 +: 5] == rs) return i + 1;
    return 0;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bus.rs1D = s.rs1D; bus.rs2D = s.rs2D; bus.rdD = s.rdD;
    bus.rs1UsedD = s.rs1UsedD; bus.rs2UsedD = s.rs2UsedD; bus.regWriteD = s.regWriteD;
    bus.rs1E = s.rs1E; bus.rs2E = s.rs2E; bus.rdE = s.rdE;
    bus.validE = s.validE; bus.regWriteE = s.regWriteE; bus.loadE = s.loadE;
    bus.longOpE = s.longOpE; bus.mispredictE = s.mispredictE;
    bus.fwdRd = s.fwdRd; bus.fwdWe = s.fwdWe;
    bus.cplValid = s.cplValid; bus.cplRd = s.cplRd;
  endtask

  // Drive one cycle, check every output against the model, then advance the model.
  task automatic runCycle(input stim_t s);
    int  occ;
    bit  full, match_d, s_e, s_d, disp;
    @(negedge clk);
    applyStimulus(s);
    #1;
    occ     = occupancy();
    full    = (occ == MO);
    match_d = s.rdE != 0 && ((s.rs1UsedD && s.rs1D == s.rdE) || (s.rs2UsedD && s.rs2D == s.rdE));
    s_e     = s.validE && s.longOpE && s.regWriteE && full;
    s_d     = s_e || (s.validE && (s.loadE || s.longOpE) && match_d) ||
              (s.rs1UsedD && busy(int'(s.rs1D), s)) || (s.rs2UsedD && busy(int'(s.rs2D), s)) ||
              (s.regWriteD && busy(int'(s.rdD), s));
    checkOutput("stallE", 32'(bus.stallE), 32'(s_e));
    checkOutput("stallD", 32'(bus.stallD), 32'(s_d));
    checkOutput("stallF", 32'(bus.stallF), 32'(s_d));
    checkOutput("flushD", 32'(bus.flushD), 32'(s.mispredictE));
    checkOutput("flushE", 32'(bus.flushE), 32'(s.mispredictE || (s_d && !s_e)));
    checkOutput("forwardAE", 32'(bus.forwardAE), fwdPick(s.rs1E, s));
    checkOutput("forwardBE", 32'(bus.forwardBE), fwdPick(s.rs2E, s));
    checkOutput("pendingCount", 32'(bus.pendingCount), occ);
    checkOutput("stallCycles", 32'(bus.stallCycles), m_stall);
    disp = s.validE && s.longOpE && s.regWriteE && s.rdE != 0 && !full;
    if (s.cplValid) m_pend[s.cplRd] = 0;
    if (disp) m_pend[s.rdE] = 1;
    if (s_d && m_stall < STALL_MAX) m_stall++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    applyStimulus(idle());
    #1;
    checkOutput("rst_pendingCount", 32'(bus.pendingCount), 0);
    checkOutput("rst_stallCycles", 32'(bus.stallCycles), 0);
    checkOutput("rst_stallD", 32'(bus.stallD), 0);
    foreach (m_pend[r]) m_pend[r] = 0;
    m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic stim_t randStim();
    stim_t s;
    s.rs1D = 5'($urandom_range(0, 7)); s.rs2D = 5'($urandom_range(0, 7));
    s.rdD  = 5'($urandom_range(0, 7));
    s.rs1E = 5'($urandom_range(0, 7)); s.rs2E = 5'($urandom_range(0, 7));
    s.rdE  = 5'($urandom_range(0, 7)); s.cplRd = 5'($urandom_range(0, 7));
    s.rs1UsedD = 1'($urandom_range(0, 1)); s.rs2UsedD = 1'($urandom_range(0, 1));
    s.regWriteD = 1'($urandom_range(0, 1));
    s.validE = ($urandom_range(0, 3) != 0);
    s.regWriteE = ($urandom_range(0, 3) != 0);
    s.longOpE = ($urandom_range(0, 2) == 0);
    s.loadE = !s.longOpE && ($urandom_range(0, 2) == 0);
    s.mispredictE = ($urandom_range(0, 7) == 0);
    s.cplValid = 1'($urandom_range(0, 1));
    s.fwdRd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    s.fwdWe = 2'($urandom_range(0, 3));
    // A real pipeline never re-dispatches to a register still in flight.
    if (s.validE && s.longOpE && s.regWriteE && s.rdE != 0 && m_pend[s.rdE] &&
        !(s.cplValid && s.cplRd == s.rdE))
      s.longOpE = 0;
    return s;
  endfunction

  initial begin
    stim_t s;
    m_stall = 0;
    foreach (m_pend[r]) m_pend[r] = 0;
    rst_n = 1'b0;
    applyStimulus(idle());
    #3;
    checkOutput("init_pendingCount", 32'(bus.pendingCount), 0);
    checkOutput("init_stallCycles", 32'(bus.stallCycles), 0);
    checkOutput("init_stallD", 32'(bus.stallD), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] long op to x5, then RAW on x5");
    runCycle(longOp(5));
    s = idle(); s.rs1D = 5; s.rs1UsedD = 1;
    runCycle(s);
    checkOutput("tp_raw_stallD", 32'(bus.stallD), 1);
    checkOutput("tp_raw_stallF", 32'(bus.stallF), 1);
    checkOutput("tp_raw_flushE", 32'(bus.flushE), 1);
    checkOutput("tp_raw_count", 32'(bus.pendingCount), 1);
    s.cplValid = 1; s.cplRd = 5;
    runCycle(s);
    checkOutput("tp_cpl_stallD", 32'(bus.stallD), 0);
    runCycle(idle());
    checkOutput("tp_cpl_count", 32'(bus.pendingCount), 0);

    $display("[TB] fill the unit");
    for (int r = 1; r <= 4; r++) runCycle(longOp(5'(r)));
    runCycle(longOp(6));
    checkOutput("tp_full_stallE", 32'(bus.stallE), 1);
    checkOutput("tp_full_stallD", 32'(bus.stallD), 1);
    checkOutput("tp_full_count", 32'(bus.pendingCount), 4);
    s = longOp(6); s.cplValid = 1; s.cplRd = 2;
    runCycle(s);
    checkOutput("tp_fullcpl_count", 32'(bus.pendingCount), 4);
    runCycle(longOp(6));
    checkOutput("tp_after_cpl_stallE", 32'(bus.stallE), 0);
    checkOutput("tp_after_cpl_count", 32'(bus.pendingCount), 3);
    s = idle(); s.rs1D = 2; s.rs1UsedD = 1;
    runCycle(s);
    checkOutput("tp_x2_free", 32'(bus.stallD), 0);
    checkOutput("tp_refill_count", 32'(bus.pendingCount), 4);
    s.rs1D = 6;
    runCycle(s);
    checkOutput("tp_x6_busy", 32'(bus.stallD), 1);
    foreach (s.fwdWe[k]) s.fwdWe[k] = 0;
    for (int r = 1; r <= 6; r++) begin
      s = idle(); s.cplValid = 1; s.cplRd = 5'(r);
      runCycle(s);
    end
    runCycle(idle());
    checkOutput("tp_drained", 32'(bus.pendingCount), 0);

    $display("[TB] load-use and forwarding");
    s = idle(); s.validE = 1; s.loadE = 1; s.regWriteE = 1; s.rdE = 7; s.rs2D = 7; s.rs2UsedD = 1;
    runCycle(s);
    checkOutput("tp_lu_stallD", 32'(bus.stallD), 1);
    checkOutput("tp_lu_flushE", 32'(bus.flushE), 1);
    s.rdE = 0; s.rs2D = 0;
    runCycle(s);
    checkOutput("tp_lu_x0", 32'(bus.stallD), 0);
    s = idle(); s.rs1E = 3; s.fwdRd = {5'd3, 5'd3}; s.fwdWe = 2'b11;
    runCycle(s);
    checkOutput("tp_fwd_both", 32'(bus.forwardAE), 1);
    s.fwdWe = 2'b10;
    runCycle(s);
    checkOutput("tp_fwd_w", 32'(bus.forwardAE), 2);
    s.rs1E = 0; s.fwdRd = 0; s.fwdWe = 2'b11;
    runCycle(s);
    checkOutput("tp_fwd_x0", 32'(bus.forwardAE), 0);

    $display("[TB] mispredict during load-use, stall counter");
    s = loadUse(7); s.mispredictE = 1;
    runCycle(s);
    checkOutput("tp_mp_flushD", 32'(bus.flushD), 1);
    checkOutput("tp_mp_flushE", 32'(bus.flushE), 1);
    checkOutput("tp_mp_stallD", 32'(bus.stallD), 1);
    doReset();
    for (int i = 0; i < 10; i++) runCycle(loadUse(7));
    runCycle(idle());
    checkOutput("tp_stall10", 32'(bus.stallCycles), 10);
    for (int i = 0; i < 10; i++) runCycle(loadUse(7));
    runCycle(idle());
    checkOutput("tp_stall_sat", 32'(bus.stallCycles), STALL_MAX);
    for (int r = 1; r <= 3; r++) runCycle(longOp(5'(r)));
    doReset();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      runCycle(randStim());
      if (i == 300) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
